// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display driver: segment bit
// positions, the all-off pattern and the active-low hex glyph table.
package seven_seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef logic [6:0] seg_pattern_t;

  // Active-low glyphs for nibbles 0..F, bit 0 = segment a, bit 6 = segment g.
  localparam seg_pattern_t SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic seg_pattern_t hex_pattern(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  // Pure table lookup into the shared glyph table.
  always_comb begin
    pattern = hex_pattern(nibble);
  end

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed hex driver for a common-anode N-digit seven-segment
// display with per-digit decimal points and blanking, PWM brightness and
// double-buffered, frame-synchronous loads.
// Optional feature: define SEVEN_SEG_LZB_EN to blank leading zero digits.
module seven_seg_mux
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DIV_BITS = 16,
  parameter int BRIGHT_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic                  load,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [7:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  logic [DIV_BITS-1:0]   cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] shadow;
  logic [4*N_DIGITS-1:0] disp;
  logic                  pending;
  logic                  frame_start;

  logic                  slot_end;
  logic                  frame_end;
  logic [N_DIGITS-1:0]   lead_zero;
  logic [3:0]            nibble;
  logic                  dp_bit;
  logic                  en_bit;
  logic                  lz_bit;
  logic                  show;
  logic                  lit;
  logic [6:0]            glyph;
  logic [7:0]            seg_next;
  logic [N_DIGITS-1:0]   an_next;

  assign slot_end  = &cnt;
  assign frame_end = slot_end && (idx == '0);

  // Slot timer and digit index; digits are scanned from leftmost down to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= LAST_IDX;
    end else begin
      cnt <= cnt + 1'b1;
      if (slot_end) begin
        idx <= (idx == '0) ? LAST_IDX : idx - 1'b1;
      end
    end
  end

  // Remembers that the current state was entered through a real frame wrap,
  // so the tick is not raised for the frame that starts out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_end;
    end
  end

  // Double buffer: loads land in shadow and are promoted only at a frame
  // boundary; a load on the boundary cycle itself goes straight to disp.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
    end else begin
      if (load) begin
        shadow <= data;
      end
      if (frame_end) begin
        pending <= 1'b0;
        if (load) begin
          disp <= data;
        end else if (pending) begin
          disp <= shadow;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

`ifdef SEVEN_SEG_LZB_EN
  // A digit is a leading zero when it and every digit to its left are zero;
  // digit 0 always stays visible so a zero value still shows "0".
  always_comb begin
    logic zero_above;
    lead_zero  = '0;
    zero_above = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zero_above   = zero_above && (disp[4*k +: 4] == 4'h0);
      lead_zero[k] = zero_above;
    end
  end
`else
  assign lead_zero = '0;
`endif

  // Select the per-digit data for the slot currently being scanned.
  always_comb begin
    nibble = '0;
    dp_bit = 1'b0;
    en_bit = 1'b0;
    lz_bit = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        nibble = disp[4*k +: 4];
        dp_bit = dp[k];
        en_bit = digit_en[k];
        lz_bit = lead_zero[k];
      end
    end
  end

  seven_seg_decode u_decode (
    .nibble  (nibble),
    .pattern (glyph)
  );

  assign show = en_bit && !lz_bit;
  assign lit  = show && (cnt != '0) && (cnt[DIV_BITS-1 -: BRIGHT_W] <= brightness);

  // Next segment and anode patterns; the anode is pulsed by the PWM window
  // and held off on the first clock of every slot to avoid ghosting.
  always_comb begin
    seg_next = SEG_BLANK;
    if (show) begin
      seg_next[6:0]  = glyph;
      seg_next[SEG_DP] = !dp_bit;
    end
    an_next = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      an_next[k] = !(lit && (idx == IDX_W'(k)));
    end
  end

  // Output registers keep every pin glitch-free and one cycle behind the scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= SEG_BLANK;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_next;
      an         <= an_next;
      frame_tick <= frame_start;
    end
  end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Self-checking bench for seven_seg_mux (N_DIGITS=4, DIV_BITS=4, BRIGHT_W=2).
// The reference model works from an elapsed-cycle count and the rule that a
// frame shows the most recent value loaded before it began.
module tb_seven_seg_mux;

  localparam int N_DIGITS = 4;
  localparam int DIV_BITS = 4;
  localparam int BRIGHT_W = 2;
  localparam int SLOT     = 1 << DIV_BITS;
  localparam int FRAME    = N_DIGITS * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic        load = 1'b0;
  logic [3:0]  dp = '0;
  logic [3:0]  digit_en = 4'hF;
  logic [1:0]  brightness = 2'd3;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;

  int          t_model;
  logic [15:0] disp_model;
  logic [15:0] latest_model;
  int          on_count;

  seven_seg_mux #(
    .N_DIGITS (N_DIGITS),
    .DIV_BITS (DIV_BITS),
    .BRIGHT_W (BRIGHT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .load       (load),
    .dp         (dp),
    .digit_en   (digit_en),
    .brightness (brightness),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Conventional active-high glyphs, segment a in bit 0.
  function automatic logic [6:0] glyphOn(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic applyStimulus(input logic new_load, input logic [15:0] new_data);
    load = new_load;
    data = new_data;
  endtask

  // Advance one clock: predict the outputs for the current model time,
  // clock the DUT, update the model and compare at the falling edge.
  task automatic checkOutput(input string tag);
    int          cnt_m;
    int          idx_m;
    logic [3:0]  nib;
    logic        show;
    logic        lit;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_tick;
    logic [15:0] upper;

    cnt_m = t_model % SLOT;
    idx_m = N_DIGITS - 1 - ((t_model / SLOT) % N_DIGITS);
    upper = disp_model >> (4 * idx_m);
    nib   = upper[3:0];
    show  = digit_en[idx_m];
`ifdef SEVEN_SEG_LZB_EN
    if (idx_m > 0 && upper == 16'h0) show = 1'b0;
`endif
    lit = show && (cnt_m != 0) && ((cnt_m / (SLOT / 4)) <= int'(brightness));
    exp_seg  = show ? {~dp[idx_m], ~glyphOn(nib)} : 8'hFF;
    exp_an   = lit ? ~(4'b0001 << idx_m) : 4'hF;
    exp_tick = (t_model > 0) && (t_model % FRAME == 0);

    @(posedge clk);
    if (load) latest_model = data;
    t_model++;
    if (t_model % FRAME == 0) disp_model = latest_model;
    @(negedge clk);

    checks++;
    assert (seg === exp_seg) else begin
      failures++;
      $error("[TB] FAIL %s seg t=%0d got=%h expected=%h", tag, t_model - 1, seg, exp_seg);
    end
    checks++;
    assert (an === exp_an) else begin
      failures++;
      $error("[TB] FAIL %s an t=%0d got=%b expected=%b", tag, t_model - 1, an, exp_an);
    end
    checks++;
    assert (frame_tick === exp_tick) else begin
      failures++;
      $error("[TB] FAIL %s frame_tick t=%0d got=%b expected=%b", tag, t_model - 1, frame_tick, exp_tick);
    end
    if (an !== 4'hF) on_count++;
  endtask

  task automatic runCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) checkOutput(tag);
  endtask

  task automatic loadPulse(input logic [15:0] value, input string tag);
    applyStimulus(1'b1, value);
    checkOutput(tag);
    applyStimulus(1'b0, value);
  endtask

  // Hold reset for n clocks, checking the outputs are off at every edge.
  task automatic resetFor(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      assert (seg === 8'hFF && an === 4'hF && frame_tick === 1'b0) else begin
        failures++;
        $error("[TB] FAIL reset_outputs got seg=%h an=%b tick=%b expected seg=ff an=1111 tick=0",
               seg, an, frame_tick);
      end
    end
    rst          = 1'b0;
    t_model      = 0;
    disp_model   = '0;
    latest_model = '0;
  endtask

  task automatic checkOnCount(input int expected, input string tag);
    checks++;
    assert (on_count === expected) else begin
      failures++;
      $error("[TB] FAIL %s on_cycles got=%0d expected=%0d", tag, on_count, expected);
    end
  endtask

  task automatic runToFrameEnd(input string tag);
    while ((t_model % FRAME) != FRAME - 1) checkOutput(tag);
  endtask

  initial begin
    @(negedge clk);
    resetFor(2);
    runCycles(40, "startup");

    $display("[TB] reset held mid-frame");
    resetFor(3);
    runCycles(3, "post_reset");

    $display("[TB] load 1A2F at full brightness");
    brightness = 2'd3;
    loadPulse(16'h1A2F, "load_1a2f");
    runCycles(2 * FRAME, "show_1a2f");

    $display("[TB] brightness sweep");
    brightness = 2'd0;
    on_count = 0;
    runCycles(FRAME, "bright0");
    checkOnCount(4 * 3, "bright0");
    brightness = 2'd1;
    on_count = 0;
    runCycles(FRAME, "bright1");
    checkOnCount(4 * 7, "bright1");
    brightness = 2'd3;
    on_count = 0;
    runCycles(FRAME, "bright3");
    checkOnCount(4 * 15, "bright3");

    $display("[TB] two loads in one frame, then load on the boundary");
    runCycles(5, "pre_double");
    loadPulse(16'h1234, "load_1234");
    runCycles(10, "between_loads");
    loadPulse(16'h5678, "load_5678");
    runCycles(FRAME + 8, "show_5678");
    runToFrameEnd("to_boundary");
    loadPulse(16'h9BCD, "load_boundary");
    runCycles(FRAME, "show_9bcd");

    $display("[TB] digit enable and decimal point");
    digit_en = 4'b1101;
    dp       = 4'b0001;
    runCycles(FRAME, "en_dp");
    digit_en = 4'hF;
    dp       = 4'h0;

    $display("[TB] leading zeros");
    loadPulse(16'h0040, "load_0040");
    runCycles(2 * FRAME, "show_0040");
    loadPulse(16'h0000, "load_0000");
    runCycles(2 * FRAME, "show_0000");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 19) == 0), 16'($urandom));
      if ($urandom_range(0, 7) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 31) == 0) brightness = 2'($urandom);
      if ($urandom_range(0, 9) == 0) data = {8'h00, 8'($urandom)};
      checkOutput("random");
    end
    applyStimulus(1'b0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
